// File: rtl/matmul_pkg.sv
// ============================================================================
// Package  : matmul_pkg
// Brief    : Shared types and sizing helpers for the matrix-multiply blocks
//            (compute controller and input memories).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package matmul_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        DRAIN    = 3'd2,
        OUT      = 3'd3,
        DONE     = 3'd4,
        WAIT_CLR = 3'd5
    } state_t;

    // Width needed to hold K in the range 0..maxk
    function automatic int k_bits_f(input int maxk);
        return $clog2(maxk + 1);
    endfunction

    // Address width of a row-major rows x cols memory
    function automatic int addr_bits_f(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

    // Smallest result width that cannot overflow for K <= maxk
    function automatic int outw_min_f(input int inw, input int maxk);
        return 2 * inw + $clog2(maxk);
    endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_ctrl_mac_acc.sv
// ============================================================================
// Module   : mac_acc
// Brief    : Signed multiply-accumulate. When enabled, adds a*b either to the
//            running sum or, on the first term of a dot product, to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_acc #(
    parameter int INW  = 12,
    parameter int OUTW = 27
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   first,
    input  logic signed [INW-1:0]  a,
    input  logic signed [INW-1:0]  b,
    output logic signed [OUTW-1:0] acc
);

    logic signed [2*INW-1:0] prod;
    logic signed [OUTW-1:0]  prod_ext;
    logic signed [OUTW-1:0]  acc_d;
    logic signed [OUTW-1:0]  acc_q;

    // Next accumulator value: clear, first-term load, accumulate, or hold
    always_comb begin
        prod     = a * b;
        prod_ext = OUTW'(prod);
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = (first ? '0 : acc_q) + prod_ext;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

`default_nettype wire

// File: rtl/matmul_ctrl.sv
// ============================================================================
// Module   : matmul_ctrl
// Brief    : Compute-side controller for C = A*B. Issues A/B reads, feeds the
//            returned operands to a MAC, streams C row-major on a
//            valid/ready output and pulses compute_finished when done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int  INW         = 12,
    parameter int  M           = 7,
    parameter int  N           = 9,
    parameter int  MAXK        = 8,
    parameter int  OUTW        = 27,
    localparam int K_BITS      = k_bits_f(MAXK),
    localparam int A_ADDR_BITS = addr_bits_f(M, MAXK),
    localparam int B_ADDR_BITS = addr_bits_f(MAXK, N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   matrices_loaded,
    input  logic [K_BITS-1:0]      K,
    output logic                   compute_finished,
    output logic [A_ADDR_BITS-1:0] A_read_addr,
    input  logic signed [INW-1:0]  A_data,
    output logic [B_ADDR_BITS-1:0] B_read_addr,
    input  logic signed [INW-1:0]  B_data,
    output logic signed [OUTW-1:0] OUT_TDATA,
    output logic                   OUT_TVALID,
    input  logic                   OUT_TREADY
);

    localparam int M_BITS = (M > 1) ? $clog2(M) : 1;
    localparam int N_BITS = (N > 1) ? $clog2(N) : 1;

    state_t                 state_q,   state_d;
    logic [K_BITS-1:0]      k_lat_q,   k_lat_d;
    logic [K_BITS-1:0]      k_q,       k_d;
    logic [M_BITS-1:0]      m_q,       m_d;
    logic [N_BITS-1:0]      n_q,       n_d;
    logic [A_ADDR_BITS-1:0] a_base_q,  a_base_d;
    logic [B_ADDR_BITS-1:0] b_addr_q,  b_addr_d;
    // Tags for the read issued last cycle; its data is on A_data/B_data now
    logic                   iss_vld_q,   iss_vld_d;
    logic                   iss_first_q, iss_first_d;
    logic                   iss_last_q,  iss_last_d;

    logic                   mac_clr;
    logic                   last_k;
    logic                   last_n;
    logic                   last_m;
    logic signed [OUTW-1:0] acc;

    // Sequencing, incremental address generation and output decode
    always_comb begin
        state_d          = state_q;
        k_lat_d          = k_lat_q;
        k_d              = k_q;
        m_d              = m_q;
        n_d              = n_q;
        a_base_d         = a_base_q;
        b_addr_d         = b_addr_q;
        iss_vld_d        = 1'b0;
        iss_first_d      = 1'b0;
        iss_last_d       = 1'b0;
        mac_clr          = 1'b0;
        A_read_addr      = '0;
        B_read_addr      = '0;
        OUT_TDATA        = '0;
        OUT_TVALID       = 1'b0;
        compute_finished = 1'b0;

        last_k = (k_q == (k_lat_q - K_BITS'(1)));
        last_n = (n_q == N_BITS'(N - 1));
        last_m = (m_q == M_BITS'(M - 1));

        case (state_q)
            IDLE: begin
                mac_clr  = 1'b1;
                k_d      = '0;
                m_d      = '0;
                n_d      = '0;
                a_base_d = '0;
                b_addr_d = '0;
                if (matrices_loaded) begin
                    k_lat_d = K;
                    state_d = (K != '0) ? RUN : DONE;
                end
            end

            RUN: begin
                A_read_addr = a_base_q + A_ADDR_BITS'(k_q);
                B_read_addr = b_addr_q;
                iss_vld_d   = 1'b1;
                iss_first_d = (k_q == '0);
                iss_last_d  = last_k;
                k_d         = k_q + K_BITS'(1);
                b_addr_d    = b_addr_q + B_ADDR_BITS'(N);
                if (last_k) begin
                    state_d = DRAIN;
                end
            end

            // Final term lands in the MAC during this cycle
            DRAIN: begin
                if (iss_last_q) begin
                    state_d = OUT;
                end
            end

            OUT: begin
                OUT_TVALID = 1'b1;
                OUT_TDATA  = acc;
                if (OUT_TREADY) begin
                    k_d = '0;
                    if (last_n) begin
                        n_d      = '0;
                        m_d      = m_q + M_BITS'(1);
                        a_base_d = a_base_q + A_ADDR_BITS'(k_lat_q);
                        b_addr_d = '0;
                    end else begin
                        n_d      = n_q + N_BITS'(1);
                        b_addr_d = B_ADDR_BITS'(n_q) + B_ADDR_BITS'(1);
                    end
                    state_d = (last_m && last_n) ? DONE : RUN;
                end
            end

            DONE: begin
                compute_finished = 1'b1;
                state_d          = WAIT_CLR;
            end

            // Wait for the load flag to drop so a stale flag cannot restart
            WAIT_CLR: begin
                if (!matrices_loaded) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and issue-tag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_lat_q     <= '0;
            k_q         <= '0;
            m_q         <= '0;
            n_q         <= '0;
            a_base_q    <= '0;
            b_addr_q    <= '0;
            iss_vld_q   <= 1'b0;
            iss_first_q <= 1'b0;
            iss_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_lat_q     <= k_lat_d;
            k_q         <= k_d;
            m_q         <= m_d;
            n_q         <= n_d;
            a_base_q    <= a_base_d;
            b_addr_q    <= b_addr_d;
            iss_vld_q   <= iss_vld_d;
            iss_first_q <= iss_first_d;
            iss_last_q  <= iss_last_d;
        end
    end

    mac_acc #(
        .INW  (INW),
        .OUTW (OUTW)
    ) u_mac_acc (
        .clk   (clk),
        .reset (reset),
        .clr   (mac_clr),
        .en    (iss_vld_q),
        .first (iss_first_q),
        .a     (A_data),
        .b     (B_data),
        .acc   (acc)
    );

endmodule

`default_nettype wire

// File: doc/matmul_ctrl.md
# matmul_ctrl

Compute-side controller for the matrix-multiply datapath. Waits for `matrices_loaded` from the input memories, then sequences reads of A (M×K) and B (K×N). It multiply-accumulates the returned operands into C = A·B and streams the M·N results out row-major on an AXI-Stream-style output. When the last result has been accepted, it pulses `compute_finished` so the input memories can accept the next matrices.

## Interface
- `INW`, 12: signed operand width.
- `M`, 7: rows of A and C.
- `N`, 9: columns of B and C.
- `MAXK`, 8: maximum shared dimension K.
- `OUTW`, 27: signed result width; must be ≥ 2·INW + $clog2(MAXK).
- localparam `K_BITS` = $clog2(MAXK+1); `A_ADDR_BITS` = $clog2(M·MAXK); `B_ADDR_BITS` = $clog2(MAXK·N).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `matrices_loaded` in 1: A/B memories hold a complete problem.
- `K` in K_BITS: shared dimension, valid while `matrices_loaded`=1.
- `compute_finished` out 1: one-cycle pulse, all results delivered.
- `A_read_addr` out A_ADDR_BITS: A read address, row-major (m·K+k).
- `A_data` in INW signed: A word; its address was presented one cycle earlier.
- `B_read_addr` out B_ADDR_BITS: B read address, row-major (k·N+n).
- `B_data` in INW signed: B word; its address was presented one cycle earlier.
- `OUT_TDATA` out OUTW signed: C[m][n].
- `OUT_TVALID` out 1: result valid.
- `OUT_TREADY` in 1: downstream accepts.

## Operation
States:
- **IDLE**: m=n=k=0, acc=0. `matrices_loaded`=1 and K≥1 → RUN. `matrices_loaded`=1 and K=0 → DONE with no output.
- **RUN**: each cycle drives `A_read_addr`=a_base+k and `B_read_addr`=k·N+n, then k++. The cycle issuing k=K−1 → DRAIN.
- **DRAIN**: last returned term accumulates; next cycle → OUT.
- **OUT**: `OUT_TVALID`=1, `OUT_TDATA`=acc, held stable until `OUT_TREADY`=1.
  - On handshake, advance (m,n) with n innermost; on n=N−1, wrap n→0, m++, a_base+=K.
  - Was (M−1,N−1) → DONE; otherwise → RUN with k=0.
- **DONE**: `compute_finished`=1 for exactly one cycle → WAIT_CLR.
- **WAIT_CLR**: stay until `matrices_loaded`=0 → IDLE. This prevents restarting on a stale load flag.

Datapath and arithmetic:
- Read-issue pipeline: 1-stage registered tags `vld_d`, `first_d`, `last_d` track the address issued last cycle.
- Accumulate: when `vld_d`=1, acc ← (`first_d` ? 0 : acc) + sext(A_data)·sext(B_data), in OUTW-bit signed two's-complement.
- No saturation; the OUTW sizing rule guarantees no overflow for K ≤ MAXK.
- Address generation is incremental (adders only, no multipliers): a_base steps by K, the B address steps by N per k.
- K is latched on the IDLE→RUN transition; later changes to `K` or `matrices_loaded` are ignored until WAIT_CLR/IDLE.
- Address outputs are 0 outside RUN.

## Timing
- Reset (`reset`=0, async): state=IDLE; `OUT_TVALID`=0, `OUT_TDATA`=0, `compute_finished`=0, address outputs 0, acc=0, counters 0.
- Reset mid-operation aborts immediately with no further outputs. After release, restart requires `matrices_loaded`=1 in IDLE.
- Per result: RUN entry → `OUT_TVALID` after K+1 cycles (K issue cycles + DRAIN). Each OUT state lasts ≥1 cycle.
- Whole job with `OUT_TREADY` tied high: M·N·(K+2) cycles from leaving IDLE to entering DONE.
- `OUT_TVALID` never drops without a handshake; `OUT_TDATA` is constant while `OUT_TVALID`=1 and `OUT_TREADY`=0.
- `compute_finished` is asserted the cycle after the final handshake and is never asserted while `OUT_TVALID`=1.

## Structure
- Package `matmul_pkg`: state enum (`IDLE, RUN, DRAIN, OUT, DONE, WAIT_CLR`) and helper functions computing K_BITS / address-width / OUTW minimums, shared with the input-memory block.
- One sub-module `mac_acc` (INW, OUTW): signed multiply, clear-on-first accumulate, enable. The FSM, counters and address generators stay in `matmul_ctrl`.

## Test plan
- Basic product: M=N=2, MAXK=4, K=2, A=[1 2;3 4], B=[5 6;7 8], `OUT_TREADY`=1 → outputs 19, 22, 43, 50 in order; one `compute_finished` pulse; total 16 cycles RUN→DONE.
- Backpressure: same job with `OUT_TREADY` low for 3 cycles on every result → identical values; `OUT_TDATA` stable while stalled; no extra memory reads during stalls.
- Extreme values (defaults): K=8, all A=B=−2048 → each of 63 outputs = 33554432, no overflow; address sequence checked against m·8+k and k·9+n.
- K edge cases:
  - K=1, A=[2],[−3]…, B row [4 … ] → products only.
  - K=0 → no `OUT_TVALID`, `compute_finished` pulse the cycle after leaving IDLE.
- Completion handshake: hold `matrices_loaded`=1 for 5 cycles after `compute_finished` → no restart; drop then reassert with new data → second job runs correctly.
- Reset mid-RUN (assert `reset`=0 asynchronously between edges) → all outputs 0 immediately; after release with `matrices_loaded`=1 → job restarts from C[0][0].
